// File: rtl/line_buffer_ctrl_if.sv
// Configuration, pixel-side and reconfigurable-bus signals of the line-buffer
// controller. The controller takes the master view; bus and pixel source take the slave view.
interface line_buffer_ctrl_if #(
    parameter int NUM_LINES         = 13,
    parameter int BITWIDTH_W_COLUMS = 4,
    parameter int BITWIDTH_W_ROWS   = 4,
    parameter int BITWIDTH_IMG      = 10
);
    logic                         LBC_Start;
    logic [BITWIDTH_W_COLUMS-1:0] LBC_W_Colums;
    logic [BITWIDTH_W_ROWS-1:0]   LBC_W_Rows;
    logic [BITWIDTH_IMG-1:0]      LBC_Img_Width;
    logic [BITWIDTH_IMG-1:0]      LBC_Img_Height;
    logic                         LBC_Pixel_Valid;
    logic                         LBC_Set_Conf_Already;
    logic                         LBC_Set_Conf;
    logic                         LBC_Set_Conf_Already_Ok;
    logic [NUM_LINES-1:0]         LBC_SetEn;
    logic [NUM_LINES-1:0]         LBC_OEn;
    logic [NUM_LINES-1:0]         LBC_Wptclr;
    logic [NUM_LINES-1:0]         LBC_Rptclr;
    logic                         LBC_Ready;
    logic                         LBC_Window_Valid;
    logic                         LBC_Busy;
    logic                         LBC_Done;
    logic                         LBC_Cfg_Err;

    modport master (
        input  LBC_Start, LBC_W_Colums, LBC_W_Rows, LBC_Img_Width, LBC_Img_Height,
               LBC_Pixel_Valid, LBC_Set_Conf_Already,
        output LBC_Set_Conf, LBC_Set_Conf_Already_Ok, LBC_SetEn, LBC_OEn, LBC_Wptclr,
               LBC_Rptclr, LBC_Ready, LBC_Window_Valid, LBC_Busy, LBC_Done, LBC_Cfg_Err
    );

    modport slave (
        output LBC_Start, LBC_W_Colums, LBC_W_Rows, LBC_Img_Width, LBC_Img_Height,
               LBC_Pixel_Valid, LBC_Set_Conf_Already,
        input  LBC_Set_Conf, LBC_Set_Conf_Already_Ok, LBC_SetEn, LBC_OEn, LBC_Wptclr,
               LBC_Rptclr, LBC_Ready, LBC_Window_Valid, LBC_Busy, LBC_Done, LBC_Cfg_Err
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line-buffer bank sequencer: bus configuration handshake, then per-buffer
// write/read/pointer-clear strobes with one-row-per-image-row buffer rotation.
module line_buffer_ctrl #(
    parameter int NUM_LINES         = 13,
    parameter int BITWIDTH_W_COLUMS = 4,
    parameter int BITWIDTH_W_ROWS   = 4,
    parameter int BITWIDTH_IMG      = 10
) (
    input  logic               LBC_Clk,
    input  logic               LBC_Reset,
    line_buffer_ctrl_if.master bus
);
    localparam int CNT_W = BITWIDTH_IMG + 1;
    localparam int WL_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef enum logic [2:0] {IDLE, CONF, ACK, CLR, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cols_reg, cols_next, rows_reg, rows_next;
    logic [CNT_W-1:0]     width_reg, width_next, height_reg, height_next;
    logic [CNT_W-1:0]     col_reg, col_next, row_reg, row_next;
    logic [WL_W-1:0]      wl_reg, wl_next;
    logic                 set_conf_reg, set_conf_next, ack_reg, ack_next;
    logic                 ready_reg, ready_next, busy_reg, busy_next;
    logic                 done_reg, done_next, cfg_err_reg, cfg_err_next;
    logic [NUM_LINES-1:0] wptclr_reg, wptclr_next, rptclr_reg, rptclr_next;
    logic [NUM_LINES-1:0] mask, onehot_wl, onehot_next;
    logic [CNT_W-1:0]     cols_m1, rows_m1, width_m1, height_m1;
    logic [31:0]          in_cols, in_rows, in_width, in_height;
    logic                 cfg_legal, accept, row_ok, row_turn;

    assign in_cols   = 32'(bus.LBC_W_Colums);
    assign in_rows   = 32'(bus.LBC_W_Rows);
    assign in_width  = 32'(bus.LBC_Img_Width);
    assign in_height = 32'(bus.LBC_Img_Height);
    assign cfg_legal = (in_rows >= 32'd1) && (in_rows <= 32'(NUM_LINES)) &&
                       (in_cols >= 32'd1) && (in_cols <= in_width) &&
                       (in_rows <= in_height) && (in_width >= 32'd1);

    assign cols_m1   = cols_reg - CNT_W'(1);
    assign rows_m1   = rows_reg - CNT_W'(1);
    assign width_m1  = width_reg - CNT_W'(1);
    assign height_m1 = height_reg - CNT_W'(1);

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_lane
            assign mask[gi]      = (rows_reg > CNT_W'(gi));
            assign onehot_wl[gi] = (wl_reg == WL_W'(gi));
        end
    endgenerate

    // ready_reg is only ever set while in RUN, so it alone qualifies a pixel
    assign accept = ready_reg & bus.LBC_Pixel_Valid;
    assign row_ok = (row_reg >= rows_m1);

    assign bus.LBC_SetEn        = accept ? onehot_wl : '0;
    assign bus.LBC_OEn          = (accept && row_ok) ? (mask & ~onehot_wl) : '0;
    assign bus.LBC_Window_Valid = accept && row_ok && (col_reg >= cols_m1);

    assign bus.LBC_Set_Conf            = set_conf_reg;
    assign bus.LBC_Set_Conf_Already_Ok = ack_reg;
    assign bus.LBC_Wptclr              = wptclr_reg;
    assign bus.LBC_Rptclr              = rptclr_reg;
    assign bus.LBC_Ready               = ready_reg;
    assign bus.LBC_Busy                = busy_reg;
    assign bus.LBC_Done                = done_reg;
    assign bus.LBC_Cfg_Err             = cfg_err_reg;

    always_ff @(posedge LBC_Clk) begin
        if (LBC_Reset) begin
            state_reg    <= IDLE;
            cols_reg     <= '0;
            rows_reg     <= '0;
            width_reg    <= '0;
            height_reg   <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            wl_reg       <= '0;
            set_conf_reg <= 1'b0;
            ack_reg      <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cfg_err_reg  <= 1'b0;
            wptclr_reg   <= '0;
            rptclr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cols_reg     <= cols_next;
            rows_reg     <= rows_next;
            width_reg    <= width_next;
            height_reg   <= height_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            wl_reg       <= wl_next;
            set_conf_reg <= set_conf_next;
            ack_reg      <= ack_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            cfg_err_reg  <= cfg_err_next;
            wptclr_reg   <= wptclr_next;
            rptclr_reg   <= rptclr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cols_next    = cols_reg;
        rows_next    = rows_reg;
        width_next   = width_reg;
        height_next  = height_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        wl_next      = wl_reg;
        cfg_err_next = 1'b0;
        row_turn     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.LBC_Start) begin
                    cols_next   = CNT_W'(bus.LBC_W_Colums);
                    rows_next   = CNT_W'(bus.LBC_W_Rows);
                    width_next  = CNT_W'(bus.LBC_Img_Width);
                    height_next = CNT_W'(bus.LBC_Img_Height);
                    if (cfg_legal) begin
                        state_next = CONF;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            CONF: begin
                if (bus.LBC_Set_Conf_Already) begin
                    state_next = ACK;
                end
            end
            ACK: state_next = CLR;
            CLR: begin
                col_next   = '0;
                row_next   = '0;
                wl_next    = '0;
                state_next = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (col_reg == width_m1) begin
                        col_next = '0;
                        if (row_reg == height_m1) begin
                            state_next = DONE;
                        end else begin
                            row_next = row_reg + CNT_W'(1);
                            wl_next  = (CNT_W'(wl_reg) == rows_m1) ? '0 : wl_reg + WL_W'(1);
                            row_turn = 1'b1;
                        end
                    end else begin
                        col_next = col_reg + CNT_W'(1);
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        onehot_next = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            onehot_next[i] = (32'(wl_next) == i);
        end

        // Registered outputs are decoded from the state being entered
        set_conf_next = (state_next == CONF);
        ack_next      = (state_next == ACK);
        busy_next     = (state_next == CONF) || (state_next == ACK) ||
                        (state_next == CLR) || (state_next == RUN);
        ready_next    = (state_next == RUN) && !row_turn;
        done_next     = (state_next == DONE);
        wptclr_next   = '0;
        rptclr_next   = '0;
        if (state_next == CLR) begin
            wptclr_next = mask;
            rptclr_next = mask;
        end else if (row_turn) begin
            wptclr_next = onehot_next;
            rptclr_next = mask & ~onehot_next;
        end
    end
endmodule
